// File: rtl/regfile_bram_mp_if.sv
// Register-file access bundle: one write port, NUM_RD_PORTS packed read ports,
// plus the ready flag and the debug probe.
interface regfile_bram_mp_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD_PORTS = 2
);
    logic                               ready;
    logic                               wr_en;
    logic [ADDR_WIDTH-1:0]              wr_addr;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic [NUM_RD_PORTS-1:0]            rd_en;
    logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0]              probe_data;

    modport master (
        input  ready, rd_data, probe_data,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr
    );

    modport slave (
        output ready, rd_data, probe_data,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr
    );
endinterface

// File: rtl/regfile_bram_mp.sv
// Multi-read-port register file on replicated block RAM: one RAM copy per read
// port plus one for the probe, all sharing a single write port.
module regfile_bram_mp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int ZERO_REG     = 1,
    parameter int PROBE_ADDR   = 15
) (
    input logic              clk,
    input logic              rst_n,
    regfile_bram_mp_if.slave bus
);
    // state | meaning
    // CLEAR | zeroing every RAM copy, one address per cycle; accesses ignored
    // RUN   | normal operation, ready high until the next reset

    localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
    localparam int                    NUM_COPIES = NUM_RD_PORTS + 1;
    localparam logic [ADDR_WIDTH:0]   CLR_LAST   = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PROBE_IDX  = ADDR_WIDTH'(PROBE_ADDR);

    typedef enum logic {CLEAR, RUN} stateT;

    stateT                 state, stateNext;
    logic [ADDR_WIDTH:0]   clrPtr, clrPtrNext;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWrData;
    logic                  wrToZero;

    assign wrToZero  = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign bus.ready = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= CLEAR;
            clrPtr <= '0;
        end else begin
            state  <= stateNext;
            clrPtr <= clrPtrNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clrPtrNext = clrPtr;
        memWe      = 1'b0;
        memAddr    = bus.wr_addr;
        memWrData  = bus.wr_data;
        case (state)
            CLEAR: begin
                memWe      = 1'b1;
                memAddr    = clrPtr[ADDR_WIDTH-1:0];
                memWrData  = '0;
                clrPtrNext = clrPtr + 1'b1;
                if (clrPtr == CLR_LAST) stateNext = RUN;
            end
            RUN: begin
                memWe = bus.wr_en && !wrToZero;
            end
            default: stateNext = CLEAR;
        endcase
        // Nothing may land in the RAM on a reset edge, including the clear write.
        if (!rst_n) memWe = 1'b0;
    end

    for (genvar c = 0; c < NUM_COPIES; c++) begin : gCopy
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [ADDR_WIDTH-1:0] rAddr;
        logic                  rEn;
        logic [DATA_WIDTH-1:0] rOut;

        if (c < NUM_RD_PORTS) begin : gPort
            assign rAddr = bus.rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            assign rEn   = bus.rd_en[c];
            assign bus.rd_data[c*DATA_WIDTH +: DATA_WIDTH] = rOut;
        end else begin : gProbe
            assign rAddr          = PROBE_IDX;
            assign rEn            = 1'b1;
            assign bus.probe_data = rOut;
        end

        always_ff @(posedge clk) begin
            if (memWe) mem[memAddr] <= memWrData;
        end

        // Forwarding covers the RAM's read-old-data behaviour on a colliding write.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rOut <= '0;
            end else if (state == RUN && rEn) begin
                if (ZERO_REG != 0 && rAddr == '0)
                    rOut <= '0;
                else if (bus.wr_en && bus.wr_addr == rAddr)
                    rOut <= bus.wr_data;
                else
                    rOut <= mem[rAddr];
            end
        end
    end
endmodule

// File: tb/tb_regfile_bram_mp.sv
// Scoreboard bench: a default 2-port instance driven through a behavioural model,
// plus a 4-port, 16-deep, no-zero-register instance checked against constants.
module tb_regfile_bram_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;
    logic rstN4;

    regfile_bram_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD_PORTS(2)) bus ();
    regfile_bram_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD_PORTS(4)) bus4 ();

    regfile_bram_mp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD_PORTS(2), .ZERO_REG(1), .PROBE_ADDR(15)
    ) dut (
        .clk(clk), .rst_n(rstN), .bus(bus)
    );

    regfile_bram_mp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD_PORTS(4), .ZERO_REG(0), .PROBE_ADDR(15)
    ) dut4 (
        .clk(clk), .rst_n(rstN4), .bus(bus4)
    );

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] val;
    } expT;

    expT         expQ[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] model[32];
    logic [31:0] lastRd[2];
    logic [31:0] probeExp;
    bit          expReady;
    int          clearCnt;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] predict(input logic [4:0] ra, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
        if (we && wa == ra) return wd;
        return model[ra];
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        lastRd[0] = 32'h0;
        lastRd[1] = 32'h0;
        probeExp  = 32'h0;
        expReady  = 1'b0;
        clearCnt  = 0;
    endtask

    // Holds rst_n low for n edges with a write and reads presented; all must vanish.
    task automatic doReset(input int n, input string tag);
        rstN        = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 32'hBAD0BAD0;
        bus.rd_en   = 2'b11;
        bus.rd_addr = {5'd3, 5'd3};
        repeat (n) @(posedge clk);
        @(negedge clk);
        rstN      = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 2'b00;
        resetModel();
        checkVal({tag, "/ready"}, {31'b0, bus.ready}, 32'h0);
        checkVal({tag, "/rd0"}, bus.rd_data[31:0], 32'h0);
        checkVal({tag, "/rd1"}, bus.rd_data[63:32], 32'h0);
        checkVal({tag, "/probe"}, bus.probe_data, 32'h0);
    endtask

    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                       input string tag);
        logic [4:0] ra[2];
        expT        e;
        ra[0] = ra0;
        ra[1] = ra1;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = {ra1, ra0};
        for (int p = 0; p < 2; p++) begin
            if (expReady && re[p]) lastRd[p] = predict(ra[p], we, wa, wd);
            expQ.push_back('{tag: $sformatf("%s/port%0d", tag, p), port: p, val: lastRd[p]});
        end
        if (expReady) begin
            probeExp = predict(5'd15, we, wa, wd);
            if (we && wa != 5'd0) model[wa] = wd;
        end else begin
            clearCnt++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 2'b00;
        if (clearCnt == 32) expReady = 1'b1;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal(e.tag, bus.rd_data[e.port*32 +: 32], e.val);
        end
        checkVal({tag, "/probe"}, bus.probe_data, probeExp);
        checkVal({tag, "/ready"}, {31'b0, bus.ready}, {31'b0, expReady});
    endtask

    task automatic step4();
        @(posedge clk);
        @(negedge clk);
        bus4.wr_en = 1'b0;
        bus4.rd_en = 4'h0;
    endtask

    initial begin
        rstN         = 1'b0;
        rstN4        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_en    = '0;
        bus.rd_addr  = '0;
        bus4.wr_en   = 1'b0;
        bus4.wr_addr = '0;
        bus4.wr_data = '0;
        bus4.rd_en   = '0;
        bus4.rd_addr = '0;

        doReset(3, "rst");
        repeat (32) cyc(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, "clr");
        for (int a = 0; a < 32; a++)
            cyc(1'b0, 5'd0, 32'h0, 2'b11, 5'(a), 5'(31 - a), "rdall");

        cyc(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, "w5");
        cyc(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5, "r5");
        cyc(1'b0, 5'd0, 32'h0, 2'b00, 5'd1, 5'd2, "hold");

        cyc(1'b1, 5'd6, 32'h66666666, 2'b00, 5'd0, 5'd0, "w6");
        cyc(1'b1, 5'd7, 32'h11111111, 2'b00, 5'd0, 5'd0, "w7");
        cyc(1'b1, 5'd7, 32'h22222222, 2'b11, 5'd6, 5'd7, "fwd");
        cyc(1'b0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd6, "fwdafter");

        cyc(1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, "zwr");
        cyc(1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, "zrd");

        cyc(1'b1, 5'd15, 32'h000000A5, 2'b00, 5'd0, 5'd0, "p15");
        cyc(1'b1, 5'd14, 32'h00005A5A, 2'b00, 5'd0, 5'd0, "p14");
        cyc(1'b0, 5'd0, 32'h0, 2'b01, 5'd14, 5'd0, "pheld");

        cyc(1'b1, 5'd9, 32'hAAAAAAAA, 2'b00, 5'd0, 5'd0, "waw1");
        cyc(1'b1, 5'd9, 32'hBBBBBBBB, 2'b01, 5'd9, 5'd0, "waw2");
        cyc(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9, "waw3");

        for (int i = 0; i < 60; i++)
            cyc(1'($urandom), 5'($urandom), $urandom, 2'($urandom),
                5'($urandom), 5'($urandom), "rand");

        cyc(1'b1, 5'd3, 32'h12345678, 2'b00, 5'd0, 5'd0, "w3");
        cyc(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd15, "r3");
        doReset(1, "midrun");
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 5'd4, 32'h00000099, 2'b11, 5'd4, 5'd3, "clrgate");
        doReset(1, "midclr");
        for (int i = 0; i < 32; i++)
            cyc(i[0], 5'd4, 32'h00000099, 2'b11, 5'd4, 5'd15, "clr2");
        cyc(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, "erased");

        // 4-port, 16-entry, no hardwired zero
        @(negedge clk);
        rstN4 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step4();
            checkVal($sformatf("clr4/%0d", k), {31'b0, bus4.ready}, (k == 16) ? 32'h1 : 32'h0);
        end
        bus4.wr_en = 1'b1; bus4.wr_addr = 4'd0; bus4.wr_data = 32'hFFFFFFFF;
        bus4.rd_en = 4'hF; bus4.rd_addr = 16'h0000;
        step4();
        for (int p = 0; p < 4; p++)
            checkVal($sformatf("z4fwd/port%0d", p), bus4.rd_data[p*32 +: 32], 32'hFFFFFFFF);
        for (int a = 1; a <= 4; a++) begin
            bus4.wr_en = 1'b1; bus4.wr_addr = 4'(a); bus4.wr_data = 32'hA0A0_0000 + 32'(a);
            step4();
        end
        bus4.rd_en = 4'hF; bus4.rd_addr = {4'd1, 4'd2, 4'd3, 4'd4};
        step4();
        for (int p = 0; p < 4; p++)
            checkVal($sformatf("r4/port%0d", p), bus4.rd_data[p*32 +: 32], 32'hA0A0_0000 + 32'(4 - p));
        bus4.rd_en = 4'h1; bus4.rd_addr = 16'h0000;
        step4();
        checkVal("z4rd", bus4.rd_data[31:0], 32'hFFFFFFFF);
        checkVal("z4held", bus4.rd_data[63:32], 32'hA0A0_0003);
        bus4.wr_en = 1'b1; bus4.wr_addr = 4'd15; bus4.wr_data = 32'h000000C3;
        step4();
        checkVal("probe4", bus4.probe_data, 32'h000000C3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/regfile_bram_mp.md
Name: regfile_bram_mp

Overview:
- Parametrised multi-read-port register file for the RISC-V core, mapped onto inferred synchronous block RAM. Each read port gets its own RAM copy; all copies share one write port.
- Generalises the fixed 2-read, 32x32 register file. Adds:
  - a configurable read-port count, width and depth;
  - registered read with read-during-write forwarding;
  - an optional hardwired zero register;
  - a parametrised debug probe port;
  - a post-reset RAM clear sequencer, because block RAM contents cannot be reset.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH.
- NUM_RD_PORTS, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = address 0 is hardwired to zero (writes dropped, reads return 0).
- PROBE_ADDR, 15, register continuously mirrored on probe_data.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ready  out  1  high once the clear sequence is complete; accesses are honoured only while high.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  NUM_RD_PORTS  per-port read strobe; bit i belongs to port i.
- rd_addr  in  NUM_RD_PORTS*ADDR_WIDTH  packed read addresses; port i is at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD_PORTS*DATA_WIDTH  packed registered read data; port i is at [i*DATA_WIDTH +: DATA_WIDTH].
- probe_data  out  DATA_WIDTH  registered value of register PROBE_ADDR.

Behaviour:
- Reset (rst_n sampled low at a clk edge):
  - state <= CLEAR, clr_ptr <= 0, ready <= 0, rd_data <= 0, probe_data <= 0.
  - RAM contents are not reset directly.
- CLEAR state:
  - Each cycle, write 0 to clr_ptr in every RAM copy, then increment clr_ptr.
  - When clr_ptr == DEPTH-1 is written, next state is RUN and ready <= 1.
  - ready therefore rises exactly DEPTH cycles after the first edge with rst_n high.
  - In CLEAR, wr_en and rd_en are ignored: writes are dropped, reads are not performed, and rd_data/probe_data hold 0.
- RUN state:
  - ready = 1. The state persists until the next reset.
- Write:
  - When wr_en=1 in RUN, wr_data is written at wr_addr into all RAM copies at the clock edge.
  - Exception: if ZERO_REG=1 and wr_addr==0, the write is dropped.
- Read latency:
  - 1 cycle. If rd_en[i]=1 in RUN at edge N, rd_data[i] is valid after edge N.
  - If rd_en[i]=0, rd_data[i] holds its previous value.
- Read value for port i:
  - If ZERO_REG=1 and rd_addr[i]==0, the value is 0.
  - Otherwise, if wr_en=1 and wr_addr==rd_addr[i] in the same cycle, the value is wr_data (new data forwarded).
  - Otherwise, the value is the RAM content before this edge.
- Ports are fully independent: any combination of addresses, including identical addresses, is legal.
- probe_data:
  - Updated every RUN cycle with the same rules, using a fixed address of PROBE_ADDR.
  - Reflects a write at PROBE_ADDR on the edge after that write.
  - If ZERO_REG=1 and PROBE_ADDR==0, probe_data is always 0.
- Write-after-write to the same address on consecutive cycles: the later value wins, and a read in the following cycle returns it.
- Reset mid-clear or mid-run:
  - The clear restarts from clr_ptr=0 and ready drops the same edge.
  - Any write presented on the reset edge is dropped.
  - Contents written before the reset are erased by the clear.
- Address width rules:
  - clr_ptr is ADDR_WIDTH+1 bits so the terminal compare has no wrap ambiguity.
  - Addresses are never truncated or extended inside the block.

Test Plan:
- Clear sequence (defaults): hold rst_n low for 3 cycles, release → ready=0 for 32 cycles, then 1. Then read all 32 addresses on both ports → every rd_data = 0, probe_data = 0.
- Write then read:
  - Write 0xDEADBEEF to x5.
  - Next cycle, read x5 on port 0 and x5 on port 1 → both return 0xDEADBEEF one cycle later.
  - rd_en held low afterwards → value held.
- Same-cycle forwarding:
  - x7 holds 0x11111111.
  - Write 0x22222222 to x7 while port 1 reads x7 → rd_data[1] = 0x22222222 after that edge.
  - Port 0 reading x6 in the same cycle → unaffected.
- Zero register: write 0xFFFFFFFF to x0 while reading x0 → read returns 0, and a later read of x0 also returns 0. With ZERO_REG=0, the same sequence returns 0xFFFFFFFF.
- Probe: write 0x000000A5 to x15 → probe_data = 0x000000A5 from the next edge onward. A write to x14 leaves probe_data unchanged.
- Reset mid-run and gating:
  - Write 0x12345678 to x3, then assert rst_n for 1 cycle → ready falls.
  - During the clear, pulse wr_en (x4=0x99) and rd_en → no effect, rd_data stays 0.
  - After ready rises, x3 and x4 both read 0.
  - Repeat with NUM_RD_PORTS=4, ADDR_WIDTH=4 → ready rises after 16 cycles.
